gpio_expander_host: RTL

- SPI initiator that drives the team's GPIO expander from a host-side design: it issues register write and read frames to the expander and returns the read data.
- It is the master-side counterpart of the expander's SPI responder and is used in the loopback bench and in the host-side integration.
- Frame format: 16 bits, MSB first, SPI mode 0.
  - Byte 0 is the command: bit7 is R/W (1 = read), bits6:0 are the address.
  - Byte 1 is the data: write data on MOSI, read data on MISO.

---
 rtl/gpio_expander_host.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/gpio_expander_host.sv
// rtl/gpio_expander_host.sv - SPI mode-0 initiator for the GPIO expander (16-bit read/write frames)
// Optional autonomous register polling is compiled in with `define GPIO_HOST_AUTO_POLL_EN.
module gpio_expander_host #(
  parameter int CLK_DIV = 4
`ifdef GPIO_HOST_AUTO_POLL_EN
  , parameter int         POLL_PERIOD = 1024
  , parameter logic [6:0] POLL_ADDR   = 7'h01
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
`ifdef GPIO_HOST_AUTO_POLL_EN
  input  logic       poll_en,
  output logic [7:0] poll_data,
  output logic       irq,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  phase_cnt;
  logic [4:0]  bit_cnt;
  logic        sclk_hi;
  logic [15:0] sr;
  logic [7:0]  rx;
  logic        is_read;
  logic        phase_last;
  logic        poll_fire;
  logic        user_read;

  assign phase_last = (phase_cnt == DIV_LAST);

`ifdef GPIO_HOST_AUTO_POLL_EN
  localparam int            PW        = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

  logic [PW-1:0] poll_cnt;
  logic          is_poll;

  assign poll_fire = poll_en && (state_q == IDLE) && (poll_cnt == POLL_LAST);
  assign user_read = is_read && !is_poll;

  // Poll interval timer: counts idle cycles, freezes during frames, and
  // stays at its terminal value when a user start wins so the poll retries.
  always_ff @(posedge clk) begin
    if (rst || !poll_en) begin
      poll_cnt <= '0;
    end else if (state_q == IDLE) begin
      if (poll_cnt == POLL_LAST) begin
        if (!start) poll_cnt <= '0;
      end else begin
        poll_cnt <= poll_cnt + 1'b1;
      end
    end
  end

  // Marks the frame in flight as autonomous, and publishes its result plus a
  // change pulse timed with the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_poll   <= 1'b0;
      poll_data <= 8'h00;
      irq       <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (state_q == IDLE) is_poll <= poll_fire && !start;
      if (state_q == HOLD && phase_last && is_poll) begin
        poll_data <= rx;
        irq       <= (rx != poll_data);
      end
    end
  end
`else
  assign poll_fire = 1'b0;
  assign user_read = is_read;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and pin/status outputs derived from the current state.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    cs_n    = 1'b0;
    sclk    = 1'b0;
    mosi    = sr[15];
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        if (start || poll_fire) state_d = SETUP;
      end
      SETUP: begin
        if (phase_last) state_d = SHIFT;
      end
      SHIFT: begin
        sclk = sclk_hi;
        if (phase_last && sclk_hi && bit_cnt == 5'd15) state_d = HOLD;
      end
      HOLD: begin
        if (phase_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: phase/bit timing, MOSI shifting on falling sclk, MISO
  // capture on rising sclk, and read-result update entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt <= 8'd0;
      bit_cnt   <= 5'd0;
      sclk_hi   <= 1'b0;
      sr        <= 16'h0000;
      rx        <= 8'h00;
      is_read   <= 1'b0;
      rdata     <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          phase_cnt <= 8'd0;
          bit_cnt   <= 5'd0;
          sclk_hi   <= 1'b0;
          if (start) begin
            sr      <= {rw, addr, wdata};
            is_read <= rw;
          end
`ifdef GPIO_HOST_AUTO_POLL_EN
          else if (poll_fire) begin
            sr      <= {1'b1, POLL_ADDR, 8'h00};
            is_read <= 1'b1;
          end
`endif
        end
        SETUP, HOLD: begin
          phase_cnt <= phase_last ? 8'd0 : phase_cnt + 8'd1;
        end
        SHIFT: begin
          if (phase_last) begin
            phase_cnt <= 8'd0;
            if (!sclk_hi) begin
              sclk_hi <= 1'b1;
              rx      <= {rx[6:0], miso};
            end else begin
              sclk_hi <= 1'b0;
              if (bit_cnt != 5'd15) begin
                bit_cnt <= bit_cnt + 5'd1;
                sr      <= {sr[14:0], 1'b0};
              end
            end
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        default: ;
      endcase
      if (state_q == HOLD && phase_last && user_read) rdata <= rx;
    end
  end

endmodule
